// File: rtl/dsp19x2_cfg_pkg.sv
// Shared constants, payload types and FSM state encoding for the DSP19X2
// mode-word reader and its coefficient bank.
package dsp19x2_cfg_pkg;

    localparam int unsigned MODE_BITS_W = 85;
    localparam int unsigned BEAT_W      = 5;
    localparam int unsigned NUM_BEATS   = 17;
    localparam int unsigned IDX0_MSB    = 84;
    localparam int unsigned IDX_W       = 20;
    localparam int unsigned COEFF_W     = 10;
    localparam int unsigned NUM_IDX     = 4;
    localparam int unsigned RSVD_W      = 4;
    localparam int unsigned RSVD_LSB    = 1;
    localparam int unsigned FRACT_BIT   = 0;
    localparam int unsigned BEAT_CNT_W  = 5;
    localparam int unsigned TO_CNT_W    = 16;

    // One coefficient index: multiplier 1 in the upper half, multiplier 2 below.
    typedef struct packed {
        logic [COEFF_W-1:0] c1;
        logic [COEFF_W-1:0] c2;
    } coeff_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        ACTIVE
    } cfg_state_t;

endpackage

// File: rtl/dsp19x2_coeff_bank.sv
// Active coefficient bank: 4 x 20-bit pairs plus RSVD/FRACTURE, updated
// atomically from the assembled mode word, with a FEEDBACK-indexed registered
// read that forces zero when FEEDBACK[2] is set or no word has been committed.
//   clk, rst_n        clock, async active-low reset
//   commit            load the whole word into the bank this cycle
//   word              assembled 85-bit mode word
//   feedback          [1:0] index select, [2] force zero
//   coeff1, coeff2    registered coefficient outputs
//   valid             bank holds a committed word
//   fracture, rsvd    committed mode fields
module dsp19x2_coeff_bank
    import dsp19x2_cfg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   commit,
    input  logic [MODE_BITS_W-1:0] word,
    input  logic [2:0]             feedback,
    output logic [COEFF_W-1:0]     coeff1,
    output logic [COEFF_W-1:0]     coeff2,
    output logic                   valid,
    output logic                   fracture,
    output logic [RSVD_W-1:0]      rsvd
);

    coeff_pair_t [NUM_IDX-1:0] bank_q;
    coeff_pair_t [NUM_IDX-1:0] bank_d;
    coeff_pair_t               sel_c;
    logic                      valid_d;
    logic                      fract_d;
    logic [RSVD_W-1:0]         rsvd_d;
    logic [COEFF_W-1:0]        coeff1_d;
    logic [COEFF_W-1:0]        coeff2_d;

    // Next bank contents; the read uses them so a commit shows up one cycle later.
    always_comb begin
        bank_d   = bank_q;
        valid_d  = valid;
        fract_d  = fracture;
        rsvd_d   = rsvd;
        coeff1_d = '0;
        coeff2_d = '0;
        if (commit) begin
            for (int k = 0; k < int'(NUM_IDX); k++) begin
                bank_d[k] = coeff_pair_t'(word[IDX0_MSB - k*IDX_W -: IDX_W]);
            end
            valid_d = 1'b1;
            fract_d = word[FRACT_BIT];
            rsvd_d  = word[RSVD_LSB +: RSVD_W];
        end
        sel_c = bank_d[feedback[1:0]];
        if (!feedback[2] && valid_d) begin
            coeff1_d = sel_c.c1;
            coeff2_d = sel_c.c2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q   <= '0;
            valid    <= 1'b0;
            fracture <= 1'b0;
            rsvd     <= '0;
            coeff1   <= '0;
            coeff2   <= '0;
        end else begin
            bank_q   <= bank_d;
            valid    <= valid_d;
            fracture <= fract_d;
            rsvd     <= rsvd_d;
            coeff1   <= coeff1_d;
            coeff2   <= coeff2_d;
        end
    end

endmodule

// File: rtl/dsp19x2_mode_bits_reader.sv
// Serial loader for the 85-bit DSP19X2 MODE_BITS word: accepts 17 five-bit
// beats MSB-first, validates FRACTURE, and commits the word atomically into
// the coefficient bank that drives COEFF1/COEFF2.
//   CLK, RESET_N                  clock, async active-low reset
//   CFG_START                     begin/restart a load
//   CFG_VALID, CFG_DATA           beat handshake and data
//   CFG_READY                     high in LOAD only
//   CFG_DONE                      one-cycle commit pulse
//   CFG_ERR                       sticky error, cleared by CFG_START
//   FEEDBACK                      coefficient index / force-zero
//   COEFF1, COEFF2, COEFF_VALID   registered coefficient outputs
//   FRACTURE, RSVD                committed mode fields
module dsp19x2_mode_bits_reader
    import dsp19x2_cfg_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               CFG_START,
    input  logic               CFG_VALID,
    input  logic [BEAT_W-1:0]  CFG_DATA,
    output logic               CFG_READY,
    output logic               CFG_DONE,
    output logic               CFG_ERR,
    input  logic [2:0]         FEEDBACK,
    output logic [COEFF_W-1:0] COEFF1,
    output logic [COEFF_W-1:0] COEFF2,
    output logic               COEFF_VALID,
    output logic               FRACTURE,
    output logic [RSVD_W-1:0]  RSVD
);

    cfg_state_t             state_q, state_d;
    logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
    logic [TO_CNT_W-1:0]    to_q, to_d;
    logic [MODE_BITS_W-1:0] shift_q, shift_d;
    logic                   ready_d, done_d, err_d;
    logic                   commit_c;
    logic                   accept_c;
    logic [TO_CNT_W:0]      gap_c;
    cfg_state_t             abort_state_c;

    assign accept_c      = CFG_VALID & CFG_READY;
    assign gap_c         = (TO_CNT_W+1)'(to_q) + (TO_CNT_W+1)'(1);
    // A failed load falls back to whatever the bank was already serving.
    assign abort_state_c = COEFF_VALID ? ACTIVE : IDLE;

    // Next-state, counters, shift register and registered-output next values.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        to_d     = to_q;
        shift_d  = shift_q;
        err_d    = CFG_ERR;
        done_d   = 1'b0;
        commit_c = 1'b0;

        unique case (state_q)
            IDLE, ACTIVE: begin
                if (CFG_START) begin
                    state_d = LOAD;
                    beat_d  = '0;
                    to_d    = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (CFG_START) begin
                    state_d = LOAD;
                    beat_d  = '0;
                    to_d    = '0;
                    err_d   = 1'b0;
                end else if (accept_c) begin
                    shift_d = {shift_q[MODE_BITS_W-BEAT_W-1:0], CFG_DATA};
                    to_d    = '0;
                    beat_d  = beat_q + BEAT_CNT_W'(1);
                    if (beat_q == BEAT_CNT_W'(NUM_BEATS - 1)) begin
                        state_d = CHECK;
                        beat_d  = '0;
                        // The last beat carries FRACTURE, so DONE can be raised in CHECK.
                        done_d  = CFG_DATA[0];
                    end
                end else if (gap_c == (TO_CNT_W+1)'(IDLE_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = abort_state_c;
                end else begin
                    to_d = gap_c[TO_CNT_W-1:0];
                end
            end
            CHECK: begin
                if (shift_q[FRACT_BIT]) begin
                    commit_c = 1'b1;
                    state_d  = ACTIVE;
                end else begin
                    err_d    = 1'b1;
                    state_d  = abort_state_c;
                end
                // A start seen here takes effect after the check has resolved.
                if (CFG_START) begin
                    state_d = LOAD;
                    beat_d  = '0;
                    to_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            to_q      <= '0;
            shift_q   <= '0;
            CFG_READY <= 1'b0;
            CFG_DONE  <= 1'b0;
            CFG_ERR   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            to_q      <= to_d;
            shift_q   <= shift_d;
            CFG_READY <= ready_d;
            CFG_DONE  <= done_d;
            CFG_ERR   <= err_d;
        end
    end

    dsp19x2_coeff_bank u_bank (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .commit   (commit_c),
        .word     (shift_q),
        .feedback (FEEDBACK),
        .coeff1   (COEFF1),
        .coeff2   (COEFF2),
        .valid    (COEFF_VALID),
        .fracture (FRACTURE),
        .rsvd     (RSVD)
    );

endmodule

// File: tb/tb_dsp19x2_mode_bits_reader.sv
// Directed bench for dsp19x2_mode_bits_reader: error word, valid load with
// FEEDBACK sweep, timeout abort, START-over-beat, async reset mid-load and
// 100 randomised loads against a small coefficient model.
module tb_dsp19x2_mode_bits_reader;

    localparam int unsigned TO = 8;

    logic       CLK;
    logic       RESET_N;
    logic       CFG_START;
    logic       CFG_VALID;
    logic [4:0] CFG_DATA;
    logic       CFG_READY;
    logic       CFG_DONE;
    logic       CFG_ERR;
    logic [2:0] FEEDBACK;
    logic [9:0] COEFF1;
    logic [9:0] COEFF2;
    logic       COEFF_VALID;
    logic       FRACTURE;
    logic [3:0] RSVD;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_bad = 0;

    logic [9:0] m_c1 [4];
    logic [9:0] m_c2 [4];

    dsp19x2_mode_bits_reader #(.IDLE_TIMEOUT(TO)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .CFG_START   (CFG_START),
        .CFG_VALID   (CFG_VALID),
        .CFG_DATA    (CFG_DATA),
        .CFG_READY   (CFG_READY),
        .CFG_DONE    (CFG_DONE),
        .CFG_ERR     (CFG_ERR),
        .FEEDBACK    (FEEDBACK),
        .COEFF1      (COEFF1),
        .COEFF2      (COEFF2),
        .COEFF_VALID (COEFF_VALID),
        .FRACTURE    (FRACTURE),
        .RSVD        (RSVD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start();
        CFG_START = 1'b1;
        tick();
        CFG_START = 1'b0;
    endtask

    function automatic logic [84:0] make_word(input logic [9:0] a0, input logic [9:0] b0,
                                              input logic [9:0] a1, input logic [9:0] b1,
                                              input logic [9:0] a2, input logic [9:0] b2,
                                              input logic [9:0] a3, input logic [9:0] b3,
                                              input logic [3:0] rs, input logic fr);
        return {a0, b0, a1, b1, a2, b2, a3, b3, rs, fr};
    endfunction

    // Sends beats first..last of w, each preceded by 0..max_gap idle cycles.
    task automatic send_beats(input logic [84:0] w, input int first, input int last, input int max_gap);
        int g;
        for (int b = first; b <= last; b++) begin
            g = 0;
            if (max_gap > 0) g = int'($urandom_range(max_gap, 0));
            CFG_VALID = 1'b0;
            repeat (g) tick();
            CFG_VALID = 1'b1;
            CFG_DATA  = w[84 - 5*b -: 5];
            if (CFG_READY !== 1'b1) ready_bad++;
            tick();
        end
        CFG_VALID = 1'b0;
    endtask

    task automatic set_model(input logic [84:0] w);
        for (int k = 0; k < 4; k++) begin
            m_c1[k] = w[84 - 20*k -: 10];
            m_c2[k] = w[74 - 20*k -: 10];
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [84:0] w_a, w_e, w_t, w_g, w_b, w_r;
        logic [9:0]  r1 [4];
        logic [9:0]  r2 [4];
        logic [3:0]  rs;
        logic [1:0]  fb;

        RESET_N   = 1'b0;
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
        CFG_DATA  = '0;
        FEEDBACK  = 3'b000;
        repeat (2) tick();

        // Reset state
        check("rst_ready",  32'(CFG_READY),   32'd0);
        check("rst_done",   32'(CFG_DONE),    32'd0);
        check("rst_err",    32'(CFG_ERR),     32'd0);
        check("rst_coeff1", 32'(COEFF1),      32'd0);
        check("rst_coeff2", 32'(COEFF2),      32'd0);
        check("rst_valid",  32'(COEFF_VALID), 32'd0);
        check("rst_fract",  32'(FRACTURE),    32'd0);
        check("rst_rsvd",   32'(RSVD),        32'd0);
        RESET_N = 1'b1;
        tick();
        check("idle_ready", 32'(CFG_READY), 32'd0);

        // FRACTURE=0 word is rejected and leaves the bank empty
        w_a = make_word(10'h100, 10'h200, 10'h101, 10'h201, 10'h102, 10'h202,
                        10'h103, 10'h203, 4'h0, 1'b1);
        w_e = make_word(10'h100, 10'h200, 10'h101, 10'h201, 10'h102, 10'h202,
                        10'h103, 10'h203, 4'h0, 1'b0);
        start();
        check("load_ready", 32'(CFG_READY), 32'd1);
        send_beats(w_e, 0, 16, 0);
        check("err_chk_done",  32'(CFG_DONE),  32'd0);
        check("err_chk_ready", 32'(CFG_READY), 32'd0);
        check("err_chk_err",   32'(CFG_ERR),   32'd0);
        tick();
        check("err_err",    32'(CFG_ERR),     32'd1);
        check("err_done",   32'(CFG_DONE),    32'd0);
        check("err_valid",  32'(COEFF_VALID), 32'd0);
        check("err_coeff1", 32'(COEFF1),      32'd0);
        check("err_coeff2", 32'(COEFF2),      32'd0);
        check("err_ready",  32'(CFG_READY),   32'd0);
        start();
        check("err_clear", 32'(CFG_ERR), 32'd0);

        // Valid load and FEEDBACK sweep
        send_beats(w_a, 0, 16, 0);
        check("a_done",  32'(CFG_DONE),  32'd1);
        check("a_ready", 32'(CFG_READY), 32'd0);
        tick();
        set_model(w_a);
        check("a_done_low", 32'(CFG_DONE),    32'd0);
        check("a_valid",    32'(COEFF_VALID), 32'd1);
        check("a_fract",    32'(FRACTURE),    32'd1);
        check("a_rsvd",     32'(RSVD),        32'd0);
        check("a_err",      32'(CFG_ERR),     32'd0);
        check("a_c1_0",     32'(COEFF1),      32'h100);
        check("a_c2_0",     32'(COEFF2),      32'h200);
        FEEDBACK = 3'd1;
        #1;
        check("a_lat_c1", 32'(COEFF1), 32'h100);
        tick();
        check("a_c1_1", 32'(COEFF1), 32'h101);
        check("a_c2_1", 32'(COEFF2), 32'h201);
        FEEDBACK = 3'd2;
        tick();
        check("a_c1_2", 32'(COEFF1), 32'h102);
        check("a_c2_2", 32'(COEFF2), 32'h202);
        FEEDBACK = 3'd3;
        tick();
        check("a_c1_3", 32'(COEFF1), 32'h103);
        check("a_c2_3", 32'(COEFF2), 32'h203);
        FEEDBACK = 3'b100;
        tick();
        check("a_zero_c1", 32'(COEFF1), 32'd0);
        check("a_zero_c2", 32'(COEFF2), 32'd0);
        FEEDBACK = 3'b111;
        tick();
        check("a_zero7_c1", 32'(COEFF1), 32'd0);
        FEEDBACK = 3'd2;
        tick();
        check("a_back_c1", 32'(COEFF1), 32'h102);

        // Timeout after beat 5: bank retained, back to ACTIVE
        w_t = make_word(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
                        10'h3FF, 10'h3FF, 4'hF, 1'b1);
        start();
        send_beats(w_t, 0, 5, 0);
        repeat (TO - 1) tick();
        check("to_pre_err",   32'(CFG_ERR),   32'd0);
        check("to_pre_ready", 32'(CFG_READY), 32'd1);
        check("to_pre_c1",    32'(COEFF1),    32'h102);
        tick();
        check("to_err",   32'(CFG_ERR),     32'd1);
        check("to_ready", 32'(CFG_READY),   32'd0);
        check("to_valid", 32'(COEFF_VALID), 32'd1);
        check("to_c1",    32'(COEFF1),      32'h102);
        check("to_c2",    32'(COEFF2),      32'h202);
        check("to_rsvd",  32'(RSVD),        32'd0);
        FEEDBACK = 3'd0;
        tick();
        check("to_c1_0", 32'(COEFF1), 32'h100);
        check("to_err_sticky", 32'(CFG_ERR), 32'd1);

        // START together with a beat: the beat is dropped, fresh word committed
        w_g = make_word(10'h155, 10'h2AA, 10'h155, 10'h2AA, 10'h155, 10'h2AA,
                        10'h155, 10'h2AA, 4'h5, 1'b1);
        w_b = make_word(10'h3A0, 10'h0B0, 10'h3A1, 10'h0B1, 10'h3A2, 10'h0B2,
                        10'h3A3, 10'h0B3, 4'h9, 1'b1);
        start();
        check("sb_err_clear", 32'(CFG_ERR), 32'd0);
        send_beats(w_g, 0, 8, 0);
        CFG_START = 1'b1;
        CFG_VALID = 1'b1;
        CFG_DATA  = w_g[84 - 45 -: 5];
        tick();
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
        check("sb_ready", 32'(CFG_READY), 32'd1);
        send_beats(w_b, 0, 15, 0);
        check("sb_no_early_done", 32'(CFG_DONE), 32'd0);
        send_beats(w_b, 16, 16, 0);
        check("sb_done", 32'(CFG_DONE), 32'd1);
        FEEDBACK = 3'd1;
        tick();
        set_model(w_b);
        check("sb_c1_1", 32'(COEFF1), 32'(m_c1[1]));
        check("sb_c2_1", 32'(COEFF2), 32'h0B1);
        check("sb_rsvd", 32'(RSVD),   32'h9);
        FEEDBACK = 3'd3;
        tick();
        check("sb_c1_3", 32'(COEFF1), 32'h3A3);
        check("sb_c2_3", 32'(COEFF2), 32'h0B3);

        // Asynchronous reset during beat 12
        start();
        send_beats(w_a, 0, 11, 0);
        CFG_VALID = 1'b1;
        CFG_DATA  = w_a[84 - 60 -: 5];
        #2;
        RESET_N = 1'b0;
        #1;
        check("ar_coeff1", 32'(COEFF1),      32'd0);
        check("ar_coeff2", 32'(COEFF2),      32'd0);
        check("ar_valid",  32'(COEFF_VALID), 32'd0);
        check("ar_ready",  32'(CFG_READY),   32'd0);
        check("ar_done",   32'(CFG_DONE),    32'd0);
        check("ar_err",    32'(CFG_ERR),     32'd0);
        check("ar_fract",  32'(FRACTURE),    32'd0);
        check("ar_rsvd",   32'(RSVD),        32'd0);
        #2;
        RESET_N = 1'b1;
        tick();
        check("ar_post_ready", 32'(CFG_READY),   32'd0);
        check("ar_post_valid", 32'(COEFF_VALID), 32'd0);
        repeat (3) tick();
        check("ar_post_ready3", 32'(CFG_READY), 32'd0);
        check("ar_post_c1",     32'(COEFF1),    32'd0);
        CFG_VALID = 1'b0;
        tick();

        // Randomised loads with sub-timeout gaps
        ready_bad = 0;
        for (int n = 0; n < 100; n++) begin
            for (int k = 0; k < 4; k++) begin
                r1[k] = 10'($urandom);
                r2[k] = 10'($urandom);
            end
            rs = 4'($urandom);
            fb = 2'($urandom);
            w_r = make_word(r1[0], r2[0], r1[1], r2[1], r1[2], r2[2], r1[3], r2[3], rs, 1'b1);
            start();
            send_beats(w_r, 0, 16, int'(TO) - 1);
            check("rnd_done",  32'(CFG_DONE),  32'd1);
            check("rnd_ready", 32'(CFG_READY), 32'd0);
            FEEDBACK = {1'b0, fb};
            tick();
            set_model(w_r);
            check("rnd_c1",    32'(COEFF1),    32'(m_c1[fb]));
            check("rnd_c2",    32'(COEFF2),    32'(m_c2[fb]));
            check("rnd_rsvd",  32'(RSVD),      32'(rs));
            check("rnd_idle_ready", 32'(CFG_READY), 32'd0);
        end
        check("rnd_ready_in_load", 32'(ready_bad), 32'd0);
        check("rnd_err", 32'(CFG_ERR), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
